// File: rtl/crc_share_arbiter.sv
// Shares one CRC engine between TX and RX: per-frame ownership, registered
// stimulus toward the engine, owner-only result routing, conflict/timeout flags.
module crc_share_arbiter #(
    parameter int DATA_W  = 8,
    parameter int CRC_W   = 5,
    parameter int TMO_CYC = 63
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_ddrccc_rx_pri,
    input  logic              i_tx_crc_en,
    input  logic              i_tx_crc_valid,
    input  logic              i_tx_crc_last,
    input  logic [DATA_W-1:0] i_tx_crc_data,
    input  logic              i_rx_crc_en,
    input  logic              i_rx_crc_valid,
    input  logic              i_rx_crc_last,
    input  logic [DATA_W-1:0] i_rx_crc_data,
    output logic              o_crc_en,
    output logic              o_crc_valid,
    output logic              o_crc_last,
    output logic [DATA_W-1:0] o_crc_data,
    input  logic [CRC_W-1:0]  i_crc_value,
    input  logic              i_crc_done,
    output logic [CRC_W-1:0]  o_tx_crc_value,
    output logic              o_tx_crc_done,
    output logic [CRC_W-1:0]  o_rx_crc_value,
    output logic              o_rx_crc_done,
    output logic [1:0]        o_owner,
    output logic              o_conflict,
    output logic              o_timeout
);

    localparam int CNT_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_TX   = 2'b01;
    localparam logic [1:0] OWN_RX   = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_TX_OWN, S_RX_OWN, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               en_q, en_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               timeout_q, timeout_d;

    logic               grant;
    logic               sel_rx;
    logic               s_en, s_valid, s_last;
    logic [DATA_W-1:0]  s_data;

    // Pick whose stimulus is considered this cycle: the arbitration winner in
    // IDLE (so its first beat is not lost), otherwise the current owner.
    always_comb begin
        grant  = 1'b0;
        sel_rx = 1'b0;
        case (state_q)
            S_IDLE: begin
                grant  = i_tx_crc_en | i_rx_crc_en;
                sel_rx = i_rx_crc_en & (~i_tx_crc_en | i_ddrccc_rx_pri);
            end
            S_TX_OWN: begin
                grant  = 1'b1;
                sel_rx = 1'b0;
            end
            S_RX_OWN: begin
                grant  = 1'b1;
                sel_rx = 1'b1;
            end
            default: begin
                grant  = 1'b0;
                sel_rx = 1'b0;
            end
        endcase
        s_en    = sel_rx ? i_rx_crc_en    : i_tx_crc_en;
        s_valid = sel_rx ? i_rx_crc_valid : i_tx_crc_valid;
        s_last  = sel_rx ? i_rx_crc_last  : i_tx_crc_last;
        s_data  = sel_rx ? i_rx_crc_data  : i_tx_crc_data;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        en_d      = 1'b0;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        data_d    = data_q;
        timeout_d = 1'b0;

        if (state_q == S_WAIT) begin
            en_d = 1'b1;
            if (i_crc_done) begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
                en_d    = 1'b0;
                cnt_d   = '0;
            end else if (cnt_q == CNT_W'(TMO_CYC - 1)) begin
                state_d   = S_IDLE;
                owner_d   = OWN_NONE;
                en_d      = 1'b0;
                cnt_d     = '0;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (grant && s_en) begin
            en_d    = 1'b1;
            valid_d = s_valid;
            last_d  = s_valid & s_last;
            if (s_valid) data_d = s_data;
            owner_d = sel_rx ? OWN_RX : OWN_TX;
            cnt_d   = '0;
            if (s_valid && s_last) state_d = S_WAIT;
            else                   state_d = sel_rx ? S_RX_OWN : S_TX_OWN;
        end else begin
            // owner dropped en mid-frame (or nobody asked): abort, no result
            state_d = S_IDLE;
            owner_d = OWN_NONE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_NONE;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            data_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            data_q    <= data_d;
            timeout_q <= timeout_d;
        end
    end

    logic wait_tx, wait_rx;

    assign wait_tx = (state_q == S_WAIT) && (owner_q == OWN_TX);
    assign wait_rx = (state_q == S_WAIT) && (owner_q == OWN_RX);

    assign o_crc_en       = en_q;
    assign o_crc_valid    = valid_q;
    assign o_crc_last     = last_q;
    assign o_crc_data     = data_q;
    assign o_owner        = owner_q;
    assign o_timeout      = timeout_q;
    assign o_tx_crc_done  = wait_tx & i_crc_done;
    assign o_rx_crc_done  = wait_rx & i_crc_done;
    assign o_tx_crc_value = wait_tx ? i_crc_value : '0;
    assign o_rx_crc_value = wait_rx ? i_crc_value : '0;
    // owner_q is non-zero exactly in the OWN/WAIT states
    assign o_conflict     = ((owner_q == OWN_TX) & i_rx_crc_en) |
                            ((owner_q == OWN_RX) & i_tx_crc_en);

endmodule

// File: tb/tb_crc_share_arbiter.sv
// Directed bench for crc_share_arbiter: frames, arbitration, abort, timeout, reset.
module tb_crc_share_arbiter;

    localparam int DATA_W = 8;
    localparam int CRC_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_pri;
    logic              tx_en, tx_valid, tx_last;
    logic [DATA_W-1:0] tx_data;
    logic              rx_en, rx_valid, rx_last;
    logic [DATA_W-1:0] rx_data;
    logic              o_crc_en, o_crc_valid, o_crc_last;
    logic [DATA_W-1:0] o_crc_data;
    logic [CRC_W-1:0]  crc_value;
    logic              crc_done;
    logic [CRC_W-1:0]  o_tx_crc_value, o_rx_crc_value;
    logic              o_tx_crc_done, o_rx_crc_done;
    logic [1:0]        o_owner;
    logic              o_conflict, o_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    crc_share_arbiter #(.DATA_W(DATA_W), .CRC_W(CRC_W), .TMO_CYC(4)) dut (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_ddrccc_rx_pri(rx_pri),
        .i_tx_crc_en(tx_en), .i_tx_crc_valid(tx_valid), .i_tx_crc_last(tx_last), .i_tx_crc_data(tx_data),
        .i_rx_crc_en(rx_en), .i_rx_crc_valid(rx_valid), .i_rx_crc_last(rx_last), .i_rx_crc_data(rx_data),
        .o_crc_en(o_crc_en), .o_crc_valid(o_crc_valid), .o_crc_last(o_crc_last), .o_crc_data(o_crc_data),
        .i_crc_value(crc_value), .i_crc_done(crc_done),
        .o_tx_crc_value(o_tx_crc_value), .o_tx_crc_done(o_tx_crc_done),
        .o_rx_crc_value(o_rx_crc_value), .o_rx_crc_done(o_rx_crc_done),
        .o_owner(o_owner), .o_conflict(o_conflict), .o_timeout(o_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_tx(input logic e, input logic v, input logic l, input logic [DATA_W-1:0] d);
        tx_en = e; tx_valid = v; tx_last = l; tx_data = d;
    endtask

    task automatic drv_rx(input logic e, input logic v, input logic l, input logic [DATA_W-1:0] d);
        rx_en = e; rx_valid = v; rx_last = l; rx_data = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_pri = 1'b0; crc_done = 1'b0; crc_value = '0;
        drv_tx(0, 0, 0, 8'h00); drv_rx(0, 0, 0, 8'h00);
        tick(); tick();
        rst = 1'b0;
        n_tests++; if (o_owner !== 2'b00) begin n_fail++; $display("FAIL rst_owner got %b exp 00", o_owner); end
        n_tests++; if (o_crc_en !== 1'b0) begin n_fail++; $display("FAIL rst_en got %b exp 0", o_crc_en); end
        n_tests++; if ({o_crc_valid, o_crc_last, o_crc_data} !== 10'h0) begin n_fail++; $display("FAIL rst_beat got %h exp 0", {o_crc_valid, o_crc_last, o_crc_data}); end
        n_tests++; if ({o_timeout, o_conflict, o_tx_crc_done, o_rx_crc_done} !== 4'h0) begin n_fail++; $display("FAIL rst_flags got %b exp 0000", {o_timeout, o_conflict, o_tx_crc_done, o_rx_crc_done}); end
    endtask

    task automatic test_tx_frame();
        drv_tx(1, 1, 0, 8'hA5); tick();
        n_tests++; if (o_owner !== 2'b01) begin n_fail++; $display("FAIL tx_owner got %b exp 01", o_owner); end
        n_tests++; if ({o_crc_en, o_crc_valid, o_crc_last, o_crc_data} !== {3'b110, 8'hA5}) begin n_fail++; $display("FAIL tx_beat0 got %h exp %h", {o_crc_en, o_crc_valid, o_crc_last, o_crc_data}, {3'b110, 8'hA5}); end
        drv_tx(1, 1, 0, 8'h3C); tick();
        n_tests++; if (o_crc_data !== 8'h3C) begin n_fail++; $display("FAIL tx_beat1 got %h exp 3c", o_crc_data); end
        drv_tx(1, 1, 1, 8'hF0); tick();
        n_tests++; if ({o_crc_en, o_crc_valid, o_crc_last, o_crc_data} !== {3'b111, 8'hF0}) begin n_fail++; $display("FAIL tx_beat2 got %h exp %h", {o_crc_en, o_crc_valid, o_crc_last, o_crc_data}, {3'b111, 8'hF0}); end
        drv_tx(1, 0, 0, 8'h00); tick();
        n_tests++; if ({o_crc_en, o_crc_valid, o_crc_last, o_owner} !== 5'b10001) begin n_fail++; $display("FAIL tx_wait got %b exp 10001", {o_crc_en, o_crc_valid, o_crc_last, o_owner}); end
        crc_done = 1'b1; crc_value = 5'h13; #1;
        n_tests++; if ({o_tx_crc_done, o_rx_crc_done} !== 2'b10) begin n_fail++; $display("FAIL tx_done got %b exp 10", {o_tx_crc_done, o_rx_crc_done}); end
        n_tests++; if ({o_tx_crc_value, o_rx_crc_value} !== {5'h13, 5'h00}) begin n_fail++; $display("FAIL tx_value got %h exp %h", {o_tx_crc_value, o_rx_crc_value}, {5'h13, 5'h00}); end
        tick(); crc_done = 1'b0; drv_tx(0, 0, 0, 8'h00); #1;
        n_tests++; if ({o_owner, o_crc_en, o_crc_valid} !== 4'b0000) begin n_fail++; $display("FAIL tx_end got %b exp 0000", {o_owner, o_crc_en, o_crc_valid}); end
        n_tests++; if (o_crc_data !== 8'hF0) begin n_fail++; $display("FAIL tx_data_hold got %h exp f0", o_crc_data); end
        tick();
    endtask

    task automatic test_rx_pri();
        rx_pri = 1'b1;
        drv_tx(1, 1, 0, 8'h11); drv_rx(1, 1, 0, 8'h22); #1;
        n_tests++; if (o_conflict !== 1'b0) begin n_fail++; $display("FAIL rxp_idle_conflict got %b exp 0", o_conflict); end
        tick();
        n_tests++; if (o_owner !== 2'b10 || o_crc_data !== 8'h22) begin n_fail++; $display("FAIL rxp_grant got %b/%h exp 10/22", o_owner, o_crc_data); end
        n_tests++; if (o_conflict !== 1'b1) begin n_fail++; $display("FAIL rxp_conflict0 got %b exp 1", o_conflict); end
        drv_tx(1, 1, 0, 8'h44); drv_rx(1, 1, 1, 8'h33); tick();
        n_tests++; if ({o_crc_last, o_crc_data, o_owner} !== {1'b1, 8'h33, 2'b10}) begin n_fail++; $display("FAIL rxp_last got %h exp %h", {o_crc_last, o_crc_data, o_owner}, {1'b1, 8'h33, 2'b10}); end
        n_tests++; if (o_conflict !== 1'b1) begin n_fail++; $display("FAIL rxp_conflict_wait got %b exp 1", o_conflict); end
        drv_tx(0, 0, 0, 8'h00); drv_rx(0, 0, 0, 8'h00); crc_done = 1'b1; crc_value = 5'h0A; #1;
        n_tests++; if (o_conflict !== 1'b0) begin n_fail++; $display("FAIL rxp_conflict_off got %b exp 0", o_conflict); end
        n_tests++; if ({o_tx_crc_done, o_rx_crc_done, o_rx_crc_value, o_tx_crc_value} !== {2'b01, 5'h0A, 5'h00}) begin n_fail++; $display("FAIL rxp_done got %h exp %h", {o_tx_crc_done, o_rx_crc_done, o_rx_crc_value, o_tx_crc_value}, {2'b01, 5'h0A, 5'h00}); end
        tick(); crc_done = 1'b0; #1;
        n_tests++; if (o_owner !== 2'b00) begin n_fail++; $display("FAIL rxp_end got %b exp 00", o_owner); end
    endtask

    task automatic test_back_to_back();
        rx_pri = 1'b0;
        drv_tx(1, 1, 0, 8'h5A); drv_rx(1, 1, 0, 8'h66); tick();
        n_tests++; if (o_owner !== 2'b01 || o_crc_data !== 8'h5A) begin n_fail++; $display("FAIL b2b_grant got %b/%h exp 01/5a", o_owner, o_crc_data); end
        n_tests++; if (o_conflict !== 1'b1) begin n_fail++; $display("FAIL b2b_conflict got %b exp 1", o_conflict); end
        drv_tx(1, 1, 1, 8'hC3); tick();
        n_tests++; if (o_crc_data !== 8'hC3 || o_crc_last !== 1'b1) begin n_fail++; $display("FAIL b2b_txlast got %h/%b exp c3/1", o_crc_data, o_crc_last); end
        drv_tx(0, 0, 0, 8'h00); crc_done = 1'b1; crc_value = 5'h1F; #1;
        n_tests++; if ({o_tx_crc_done, o_rx_crc_done} !== 2'b10) begin n_fail++; $display("FAIL b2b_txdone got %b exp 10", {o_tx_crc_done, o_rx_crc_done}); end
        tick(); crc_done = 1'b0; drv_rx(1, 1, 0, 8'h77); #1;
        n_tests++; if (o_owner !== 2'b00 || o_conflict !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b/%b exp 00/0", o_owner, o_conflict); end
        tick();
        n_tests++; if (o_owner !== 2'b10 || o_crc_data !== 8'h77) begin n_fail++; $display("FAIL b2b_rxgrant got %b/%h exp 10/77", o_owner, o_crc_data); end
        drv_rx(1, 1, 1, 8'h88); tick();
        drv_rx(0, 0, 0, 8'h00); crc_done = 1'b1; crc_value = 5'h05; #1;
        n_tests++; if ({o_tx_crc_done, o_rx_crc_done, o_rx_crc_value} !== {2'b01, 5'h05}) begin n_fail++; $display("FAIL b2b_rxdone got %h exp %h", {o_tx_crc_done, o_rx_crc_done, o_rx_crc_value}, {2'b01, 5'h05}); end
        tick(); crc_done = 1'b0; #1;
    endtask

    task automatic test_timeout();
        drv_tx(1, 1, 1, 8'h99); tick();
        n_tests++; if ({o_owner, o_crc_last, o_crc_data} !== {2'b01, 1'b1, 8'h99}) begin n_fail++; $display("FAIL tmo_single got %h exp %h", {o_owner, o_crc_last, o_crc_data}, {2'b01, 1'b1, 8'h99}); end
        drv_tx(0, 0, 0, 8'h00);
        tick(); tick(); tick();
        n_tests++; if ({o_timeout, o_owner, o_crc_en} !== 4'b0011) begin n_fail++; $display("FAIL tmo_early got %b exp 0011", {o_timeout, o_owner, o_crc_en}); end
        tick();
        n_tests++; if ({o_timeout, o_owner, o_crc_en} !== 4'b1000) begin n_fail++; $display("FAIL tmo_fire got %b exp 1000", {o_timeout, o_owner, o_crc_en}); end
        tick();
        n_tests++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse got %b exp 0", o_timeout); end
        crc_done = 1'b1; crc_value = 5'h1A; #1;
        n_tests++; if ({o_tx_crc_done, o_rx_crc_done} !== 2'b00) begin n_fail++; $display("FAIL tmo_stray got %b exp 00", {o_tx_crc_done, o_rx_crc_done}); end
        tick(); crc_done = 1'b0;
    endtask

    task automatic test_abort();
        drv_rx(1, 1, 0, 8'h12); tick();
        drv_rx(1, 1, 0, 8'h34); tick();
        n_tests++; if (o_owner !== 2'b10 || o_crc_data !== 8'h34) begin n_fail++; $display("FAIL abt_beat got %b/%h exp 10/34", o_owner, o_crc_data); end
        drv_rx(1, 0, 0, 8'hFF); tick();
        n_tests++; if ({o_crc_en, o_crc_valid, o_crc_data} !== {2'b10, 8'h34}) begin n_fail++; $display("FAIL abt_bubble got %h exp %h", {o_crc_en, o_crc_valid, o_crc_data}, {2'b10, 8'h34}); end
        drv_rx(0, 0, 0, 8'h00); tick();
        n_tests++; if ({o_owner, o_crc_en, o_crc_valid} !== 4'b0000) begin n_fail++; $display("FAIL abt_idle got %b exp 0000", {o_owner, o_crc_en, o_crc_valid}); end
        crc_done = 1'b1; crc_value = 5'h07; #1;
        n_tests++; if ({o_tx_crc_done, o_rx_crc_done} !== 2'b00) begin n_fail++; $display("FAIL abt_nodone got %b exp 00", {o_tx_crc_done, o_rx_crc_done}); end
        tick(); crc_done = 1'b0;
    endtask

    task automatic test_reset_mid();
        drv_tx(1, 1, 0, 8'hAB); tick();
        n_tests++; if (o_owner !== 2'b01) begin n_fail++; $display("FAIL rmid_own got %b exp 01", o_owner); end
        rst = 1'b1; drv_rx(1, 0, 0, 8'h00); tick();
        n_tests++; if ({o_owner, o_crc_en, o_crc_valid, o_crc_last, o_crc_data} !== 13'h0) begin n_fail++; $display("FAIL rmid_out got %h exp 0", {o_owner, o_crc_en, o_crc_valid, o_crc_last, o_crc_data}); end
        n_tests++; if ({o_conflict, o_timeout} !== 2'b00) begin n_fail++; $display("FAIL rmid_flags got %b exp 00", {o_conflict, o_timeout}); end
        rst = 1'b0; drv_tx(0, 0, 0, 8'h00); drv_rx(0, 0, 0, 8'h00);
        crc_done = 1'b1; crc_value = 5'h11; #1;
        n_tests++; if ({o_tx_crc_done, o_rx_crc_done} !== 2'b00) begin n_fail++; $display("FAIL rmid_stray got %b exp 00", {o_tx_crc_done, o_rx_crc_done}); end
        tick(); crc_done = 1'b0; tick();
        n_tests++; if (o_owner !== 2'b00) begin n_fail++; $display("FAIL rmid_idle got %b exp 00", o_owner); end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_rx_pri();
        test_back_to_back();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
